ucmp8: RTL
==========

UCMP8 -- requirements
Module: ucmp8

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port _areset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port dcount, input, 8 bits: count value from the upstream 8-bit counter.
REQ-004 SHALL have port overflow, input, 1 bit: overflow flag from the upstream counter.
REQ-005 SHALL have port cfg_wr, input, 1 bit: one-cycle configuration write strobe.
REQ-006 SHALL have port cfg_cmp, input, 8 bits: compare value, captured on cfg_wr.
REQ-007 SHALL have port cfg_mode, input, 2 bits: mode, captured on cfg_wr; 00 OFF, 01 ONESHOT, 10 PERIODIC, 11 PWM.
REQ-008 SHALL have port irq_ack, input, 1 bit: interrupt acknowledge, level-sampled.
REQ-009 SHALL have port match, output, 1 bit: one-cycle compare-hit pulse.
REQ-010 SHALL have port irq, output, 1 bit: interrupt request, held high until acknowledged.
REQ-011 SHALL have port pwm_out, output, 1 bit: registered PWM output.
REQ-012 SHALL have port miss_cnt, output, 4 bits: count of hits lost while irq was pending.
REQ-013 SHALL have port ovf_seen, output, 1 bit: sticky flag, upstream overflow seen.
REQ-014 SHALL have port cmp_q, output, 8 bits: active compare value.

Function
REQ-015 SHALL register dcount into dcount_prev every cycle; chg = prev_valid && (dcount != dcount_prev); prev_valid goes to 1 one cycle after reset.
REQ-016 SHALL define hit = chg && (dcount == cmp_q) && state in {ARMED, PENDING}; a counter held static SHALL never produce repeated hits.
REQ-017 SHALL pulse match high for exactly the one cycle after the edge at which hit was sampled (latency 1).
REQ-018 SHALL implement states IDLE, ARMED, PENDING, DONE.
REQ-019 IDLE->ARMED on cfg_wr with cfg_mode!=OFF; cmp_q and mode load directly from cfg_cmp/cfg_mode.
REQ-020 ARMED->PENDING on hit; irq is set at the same edge as match.
REQ-021 PENDING->ARMED on irq_ack (PERIODIC, PWM); PENDING->DONE on irq_ack (ONESHOT).
REQ-022 irq_ack with hit in the same cycle (PERIODIC/PWM): stay PENDING, irq stays high, miss_cnt unchanged.
REQ-023 hit in PENDING without irq_ack: miss_cnt increments, saturating at 15; state unchanged.
REQ-024 DONE ignores hits (no match, no irq); cfg_wr with mode!=OFF in DONE re-arms to ARMED with direct load.
REQ-025 cfg_wr with cfg_mode=OFF from any state: to IDLE, irq cleared, match suppressed.
REQ-026 cfg_wr with mode!=OFF in ARMED/PENDING: mode updates immediately; cfg_cmp goes to a shadow register, copied to cmp_q on wrap (chg with dcount_prev=255,dcount=0 or dcount_prev=0,dcount=255).
REQ-027 Any cfg_wr SHALL clear miss_cnt and ovf_seen.
REQ-028 ovf_seen SHALL set on a rising edge of overflow and hold until cfg_wr or reset; set wins over clear in the same cycle.
REQ-029 pwm_out (next) = (mode==PWM) && state!=IDLE && (dcount < cmp_q); cmp_q=0 gives constant low; cmp_q=255 gives low only at dcount=255.
REQ-030 irq_ack when irq is low SHALL have no effect.

Reset
REQ-031 On _areset: state IDLE, mode OFF, cmp_q=0, shadow=0, dcount_prev=0, prev_valid=0, match=0, irq=0, pwm_out=0, miss_cnt=0, ovf_seen=0.
REQ-032 _areset SHALL take priority over every other input, including mid-PENDING and coincident cfg_wr.

Structure
REQ-033 Package ucmp8_pkg SHALL hold mode encodings, state encodings, and MISS_MAX=15.
REQ-034 Change/wrap detection (dcount_prev, prev_valid, chg, wrap) SHALL be a sub-module ucmp8_sample; the FSM, registers and PWM logic live in ucmp8.

Verification
REQ-035 Reset; cfg_wr cmp=0x10 mode=PERIODIC; count 0x00..0x20 -> one match pulse 1 cycle after dcount=0x10, irq high, state PENDING.
REQ-036 Continuing without ack, count wraps to 0x10 three times -> miss_cnt=3, irq still high; irq_ack -> irq low, ARMED.
REQ-037 ONESHOT cmp=0x05; hit, ack -> DONE; further passes through 0x05 -> no match, no irq.
REQ-038 PWM cmp=0x40, free-running up count -> pwm_out high 64 of 256 cycles; cfg_wr cmp=0x80 mid-period -> new duty only after wrap.
REQ-039 Hold dcount=0x10 for 10 cycles at cmp=0x10 -> exactly one match; irq_ack coincident with hit -> irq stays high, miss_cnt=0.
REQ-040 overflow pulse -> ovf_seen=1; _areset asserted in PENDING -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ucmp8_pkg.sv
// Shared encodings for the ucmp8 compare/interrupt block.
package ucmp8_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_PWM      = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_PENDING = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    localparam logic [3:0] MISS_MAX = 4'd15;

endpackage

// File: rtl/ucmp8_sample.sv
// Tracks the previous upstream count and flags value changes and 0<->255 wraps.
module ucmp8_sample (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dcount,
    output logic       chg,
    output logic       wrap
);

    logic [7:0] dcount_prev;
    logic       prev_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            dcount_prev <= 8'h00;
            prev_valid  <= 1'b0;
        end else begin
            dcount_prev <= dcount;
            prev_valid  <= 1'b1;
        end
    end

    assign chg  = prev_valid && (dcount != dcount_prev);
    assign wrap = chg && (((dcount_prev == 8'hFF) && (dcount == 8'h00)) ||
                          ((dcount_prev == 8'h00) && (dcount == 8'hFF)));

endmodule

// File: rtl/ucmp8.sv
// Compare unit for an upstream 8-bit counter: match pulse, sticky irq, miss count, PWM.
//
// state   | meaning
// IDLE    | disabled, compare ignored
// ARMED   | waiting for a compare hit
// PENDING | irq raised, waiting for irq_ack
// DONE    | oneshot consumed, hits ignored until re-armed
module ucmp8
    import ucmp8_pkg::*;
(
    input  logic       clk,
    input  logic       _areset,
    input  logic [7:0] dcount,
    input  logic       overflow,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_cmp,
    input  logic [1:0] cfg_mode,
    input  logic       irq_ack,
    output logic       match,
    output logic       irq,
    output logic       pwm_out,
    output logic [3:0] miss_cnt,
    output logic       ovf_seen,
    output logic [7:0] cmp_q
);

    state_e     state, state_nxt;
    mode_e      mode_q;
    logic [7:0] shadow;
    logic       overflow_q;
    logic       chg, wrap, hit, live, off_wr, arm_wr;
    logic       match_nxt, irq_nxt, pwm_nxt, ovf_nxt;
    logic [3:0] miss_nxt;

    ucmp8_sample u_sample (
        .clk    (clk),
        .reset  (_areset),
        .dcount (dcount),
        .chg    (chg),
        .wrap   (wrap)
    );

    assign live   = (state == ST_ARMED) || (state == ST_PENDING);
    assign off_wr = cfg_wr && (cfg_mode == MODE_OFF);
    assign arm_wr = cfg_wr && (cfg_mode != MODE_OFF);
    assign hit    = chg && (dcount == cmp_q) && live;

    always_ff @(posedge clk) begin
        if (_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (off_wr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (arm_wr) state_nxt = ST_ARMED;
                ST_ARMED:   if (hit) state_nxt = ST_PENDING;
                ST_PENDING: begin
                    // A coincident hit re-raises the interrupt in the repeating modes.
                    if (irq_ack) begin
                        if (mode_q == MODE_ONESHOT) state_nxt = ST_DONE;
                        else if (!hit)              state_nxt = ST_ARMED;
                    end
                end
                ST_DONE:    if (arm_wr) state_nxt = ST_ARMED;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        match_nxt = hit && !off_wr;
        irq_nxt   = (state_nxt == ST_PENDING);
        pwm_nxt   = (mode_q == MODE_PWM) && (state != ST_IDLE) && (dcount < cmp_q);
        miss_nxt  = miss_cnt;
        if (cfg_wr) begin
            miss_nxt = 4'd0;
        end else if ((state == ST_PENDING) && hit && !irq_ack && (miss_cnt != MISS_MAX)) begin
            miss_nxt = miss_cnt + 4'd1;
        end
        ovf_nxt = ovf_seen;
        if (overflow && !overflow_q) begin
            ovf_nxt = 1'b1;
        end else if (cfg_wr) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (_areset) begin
            match      <= 1'b0;
            irq        <= 1'b0;
            pwm_out    <= 1'b0;
            miss_cnt   <= 4'd0;
            ovf_seen   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            match      <= match_nxt;
            irq        <= irq_nxt;
            pwm_out    <= pwm_nxt;
            miss_cnt   <= miss_nxt;
            ovf_seen   <= ovf_nxt;
            overflow_q <= overflow;
        end
    end

    // While running, new compare values wait in the shadow until the count wraps.
    always_ff @(posedge clk) begin
        if (_areset) begin
            mode_q <= MODE_OFF;
            cmp_q  <= 8'h00;
            shadow <= 8'h00;
        end else begin
            if (wrap && live) cmp_q <= shadow;
            if (cfg_wr) begin
                mode_q <= mode_e'(cfg_mode);
                if (arm_wr) begin
                    shadow <= cfg_cmp;
                    if (!live) cmp_q <= cfg_cmp;
                end
            end
        end
    end

endmodule
